// File: rtl/hex_scan_display.sv
// hex_scan_display: multi-digit hexadecimal seven-segment driver.
//
// A Load commits Value into a shadow register; the digit registers are then
// updated one digit per cycle (digit 0 first) while Busy is high. Each digit
// is decoded to active-low segments and may be blanked by a free-running
// blink phase when its Blink_mask bit is set.
//
// Optional feature: define HEX_SCAN_DISPLAY_LZB_EN to enable leading-zero
// blanking (digits above digit 0 that are zero, with all higher digits also
// zero, are blanked). Without the macro every digit always displays.
module hex_scan_display #(
  parameter int DIGITS    = 6,
  parameter int BLINK_DIV = 25000000
) (
  input  logic                  Clock,
  input  logic                  Resetn,
  input  logic                  Load,
  input  logic [4*DIGITS-1:0]   Value,
  input  logic [DIGITS-1:0]     Blink_mask,
  output logic                  Busy,
  output logic [4*DIGITS-1:0]   Shown,
  output logic [7*DIGITS-1:0]   HEX
);

  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int CW = $clog2(BLINK_DIV);
  localparam logic [IW-1:0] LAST_IDX = IW'(DIGITS - 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(BLINK_DIV - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    WRITE = 1'b1
  } state_e;

  state_e              state_q, state_d;
  logic                busy_q, busy_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [4*DIGITS-1:0] shadow_q, shadow_d;
  logic [4*DIGITS-1:0] digits_q, digits_d;
  logic [CW-1:0]       blink_cnt_q, blink_cnt_d;
  logic                blink_phase_q, blink_phase_d;

  // Active-low segment pattern for one hex nibble (bit 0 = a ... bit 6 = g).
  function automatic logic [6:0] decode_hex(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      default: seg = 7'h0E;
    endcase
    return seg;
  endfunction

  // Next-state logic for the load/write sequencer.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
    state_d  = state_q;
    busy_d   = busy_q;
    idx_d    = idx_q;
    shadow_d = shadow_q;
    digits_d = digits_q;
    case (state_q)
      IDLE: begin
        if (Load) begin
          shadow_d = Value;
          idx_d    = '0;
          state_d  = WRITE;
          busy_d   = 1'b1;
        end
      end
      WRITE: begin
        digits_d[4*int'(idx_q) +: 4] = shadow_q[4*int'(idx_q) +: 4];
        if (idx_q == LAST_IDX) begin
          idx_d   = '0;
          state_d = IDLE;
          busy_d  = 1'b0;
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // Free-running blink divider, independent of the load sequencer.
  always_comb begin
    blink_cnt_d   = (blink_cnt_q == CNT_MAX) ? '0 : blink_cnt_q + CW'(1);
    blink_phase_d = blink_phase_q ^ (blink_cnt_q == CNT_MAX);
  end

  // State registers; reset aborts any update in progress.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      // NOTE: the digit and shadow registers are reset too, because the display must read 0 after reset.
      state_q       <= IDLE;
      busy_q        <= 1'b0;
      idx_q         <= '0;
      shadow_q      <= '0;
      digits_q      <= '0;
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q       <= state_d;
      busy_q        <= busy_d;
      idx_q         <= idx_d;
      shadow_q      <= shadow_d;
      digits_q      <= digits_d;
      blink_cnt_q   <= blink_cnt_d;
      blink_phase_q <= blink_phase_d;
    end
  end

  assign Busy  = busy_q;
  assign Shown = digits_q;

  // Segment output: decode each digit register, then apply blink and blanking.
  always_comb begin
`ifdef HEX_SCAN_DISPLAY_LZB_EN
    logic zero_run;
    zero_run = 1'b1;
`endif
    HEX = '1;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      logic blank;
      blank = Blink_mask[k] & blink_phase_q;
`ifdef HEX_SCAN_DISPLAY_LZB_EN
      // zero_run stays high while this digit and every digit above it are zero.
      zero_run = zero_run & (digits_q[4*k +: 4] == 4'h0);
      if ((k > 0) && zero_run) blank = 1'b1;
`endif
      HEX[7*k +: 7] = blank ? 7'h7F : decode_hex(digits_q[4*k +: 4]);
    end
  end

endmodule

// File: tb/tb_hex_scan_display.sv
// Self-checking bench for hex_scan_display (DIGITS=6, BLINK_DIV=4, plus a
// DIGITS=1 instance). Expected values come from a behavioural model that
// tracks pending digit writes and the number of clock edges since reset.
module tb_hex_scan_display;

  localparam int DIGITS    = 6;
  localparam int BLINK_DIV = 4;

  logic        Clock = 1'b0;
  logic        Resetn;
  logic        Load;
  logic [23:0] Value;
  logic [5:0]  Blink_mask;
  logic        Busy;
  logic [23:0] Shown;
  logic [41:0] HEX;

  logic        load1;
  logic [3:0]  value1;
  logic [0:0]  mask1;
  logic        busy1;
  logic [3:0]  shown1;
  logic [6:0]  hex1;

  int pass_cnt  = 0;
  int total_cnt = 0;

  // Reference model state.
  int          m_left;   // digit writes still pending
  int          m_edges;  // rising edges seen since reset release
  logic [23:0] m_shadow;
  logic [23:0] m_shown;

  logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  hex_scan_display #(.DIGITS(DIGITS), .BLINK_DIV(BLINK_DIV)) dut (
    .Clock(Clock), .Resetn(Resetn), .Load(Load), .Value(Value),
    .Blink_mask(Blink_mask), .Busy(Busy), .Shown(Shown), .HEX(HEX)
  );

  hex_scan_display #(.DIGITS(1), .BLINK_DIV(BLINK_DIV)) dut1 (
    .Clock(Clock), .Resetn(Resetn), .Load(load1), .Value(value1),
    .Blink_mask(mask1), .Busy(busy1), .Shown(shown1), .HEX(hex1)
  );

  always #5 Clock = ~Clock;

  function automatic logic exp_busy();
    return m_left > 0;
  endfunction

  function automatic logic [41:0] exp_hex(input logic [5:0] mask);
    logic [41:0] h;
    int phase;
    phase = (m_edges / BLINK_DIV) % 2;
    h = '1;
    for (int k = 0; k < DIGITS; k++) begin
      logic blank;
      blank = mask[k] && (phase == 1);
`ifdef HEX_SCAN_DISPLAY_LZB_EN
      if (k > 0 && (m_shown >> (4 * k)) == 24'h0) blank = 1'b1;
`endif
      h[7*k +: 7] = blank ? 7'h7F : seg_tab[m_shown[4*k +: 4]];
    end
    return h;
  endfunction

  function automatic logic [41:0] reset_hex();
`ifdef HEX_SCAN_DISPLAY_LZB_EN
    return {{5{7'h7F}}, 7'h40};
`else
    return {6{7'h40}};
`endif
  endfunction

  task automatic model_reset();
    m_left   = 0;
    m_edges  = 0;
    m_shadow = '0;
    m_shown  = '0;
  endtask

  // One clock: sample inputs, advance the model on the edge, settle 1 time unit.
  task automatic tick();
    logic        ld;
    logic [23:0] v;
    ld = Load;
    v  = Value;
    @(posedge Clock);
    if (Resetn) begin
      m_edges++;
      if (m_left > 0) begin
        int k;
        k = DIGITS - m_left;
        m_shown[4*k +: 4] = m_shadow[4*k +: 4];
        m_left--;
      end else if (ld) begin
        m_shadow = v;
        m_left   = DIGITS;
      end
    end
    #1;
  endtask

  task automatic drain(input string name);
    for (int g = 0; g < 20 && Busy; g++) tick();
    total_cnt++;
    if (Busy !== 1'b0) $display("FAIL %s_timeout: Busy=%b still high, want 0", name, Busy);
    else pass_cnt++;
  endtask

  task automatic test_reset();
    Resetn = 1'b0; Load = 1'b0; Value = '0; Blink_mask = '0;
    load1 = 1'b0; value1 = '0; mask1 = '0;
    #12;
    model_reset();
    total_cnt++;
    if (Busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", Busy); else pass_cnt++;
    total_cnt++;
    if (Shown !== 24'h0) $display("FAIL reset_shown: got %h want 000000", Shown); else pass_cnt++;
    total_cnt++;
    if (HEX !== reset_hex()) $display("FAIL reset_hex: got %h want %h", HEX, reset_hex());
    else pass_cnt++;
    Resetn = 1'b1;
  endtask

  task automatic test_single_load();
    int busy_cycles;
    Value = 24'h12AB3F; Load = 1'b1;
    tick();
    Load = 1'b0; Value = $urandom;
    total_cnt++;
    if (Busy !== 1'b1) $display("FAIL first_load_accept: Busy=%b want 1", Busy); else pass_cnt++;
    busy_cycles = 1;
    for (int i = 0; i < 20 && Busy; i++) begin
      tick();
      total_cnt++;
      if (Shown !== m_shown) $display("FAIL single_shown cyc %0d: got %h want %h", i, Shown, m_shown);
      else pass_cnt++;
      total_cnt++;
      if (Busy !== exp_busy()) $display("FAIL single_busy cyc %0d: got %b want %b", i, Busy, exp_busy());
      else pass_cnt++;
      if (Busy) busy_cycles++;
    end
    total_cnt++;
    if (busy_cycles != 6) $display("FAIL single_busy_len: got %0d want 6", busy_cycles); else pass_cnt++;
    total_cnt++;
    if (Shown !== 24'h12AB3F) $display("FAIL single_final_shown: got %h want 12ab3f", Shown); else pass_cnt++;
    total_cnt++;
    if (HEX !== {7'h79, 7'h24, 7'h08, 7'h03, 7'h30, 7'h0E})
      $display("FAIL single_hex: got %h want %h", HEX, {7'h79, 7'h24, 7'h08, 7'h03, 7'h30, 7'h0E});
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    Load = 1'b1;
    for (int i = 0; i < 20; i++) begin
      Value = (i < 10) ? 24'h000001 : 24'h000002;
      tick();
      total_cnt++;
      if (Busy !== exp_busy()) $display("FAIL b2b_busy cyc %0d: got %b want %b", i, Busy, exp_busy());
      else pass_cnt++;
      total_cnt++;
      if (Shown !== m_shown) $display("FAIL b2b_shown cyc %0d: got %h want %h", i, Shown, m_shown);
      else pass_cnt++;
    end
    Load = 1'b0;
    drain("b2b");
    total_cnt++;
    if (Shown !== 24'h000002) $display("FAIL b2b_final: got %h want 000002", Shown); else pass_cnt++;
  endtask

  task automatic test_blink();
    Blink_mask = 6'b000001; Value = 24'h000008; Load = 1'b1;
    tick();
    Load = 1'b0;
    drain("blink");
    for (int i = 0; i < 16; i++) begin
      tick();
      total_cnt++;
      if (HEX !== exp_hex(Blink_mask)) $display("FAIL blink_hex cyc %0d: got %h want %h", i, HEX, exp_hex(Blink_mask));
      else pass_cnt++;
      total_cnt++;
      if (HEX[41:7] !== {5{7'h40}}) $display("FAIL blink_others cyc %0d: got %h want %h", i, HEX[41:7], {5{7'h40}});
      else pass_cnt++;
    end
    Blink_mask = '0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      Load = ($urandom_range(0, 2) == 0);
      Value = $urandom;
      Blink_mask = 6'($urandom);
      tick();
      #1;
      total_cnt++;
      if (Busy !== exp_busy()) $display("FAIL rand_busy cyc %0d: got %b want %b", i, Busy, exp_busy());
      else pass_cnt++;
      total_cnt++;
      if (Shown !== m_shown) $display("FAIL rand_shown cyc %0d: got %h want %h", i, Shown, m_shown);
      else pass_cnt++;
      total_cnt++;
      if (HEX !== exp_hex(Blink_mask)) $display("FAIL rand_hex cyc %0d: got %h want %h", i, HEX, exp_hex(Blink_mask));
      else pass_cnt++;
    end
    Load = 1'b0; Blink_mask = '0;
    drain("rand");
  endtask

  task automatic test_reset_mid_write();
    Value = 24'hFFFFFF; Load = 1'b1;
    tick();
    Load = 1'b0;
    tick();
    tick();
    #2;
    Resetn = 1'b0;
    #1;
    model_reset();
    total_cnt++;
    if (Busy !== 1'b0) $display("FAIL midrst_busy: got %b want 0", Busy); else pass_cnt++;
    total_cnt++;
    if (Shown !== 24'h0) $display("FAIL midrst_shown: got %h want 000000", Shown); else pass_cnt++;
    total_cnt++;
    if (HEX !== reset_hex()) $display("FAIL midrst_hex: got %h want %h", HEX, reset_hex()); else pass_cnt++;
    #10;
    Resetn = 1'b1;
    Value = 24'h5A5A5A; Load = 1'b1;
    tick();
    Load = 1'b0;
    total_cnt++;
    if (Busy !== 1'b1) $display("FAIL post_reset_load: Busy=%b want 1", Busy); else pass_cnt++;
    drain("midrst");
    total_cnt++;
    if (Shown !== 24'h5A5A5A) $display("FAIL post_reset_shown: got %h want 5a5a5a", Shown); else pass_cnt++;
  endtask

  task automatic test_lzb();
    logic [41:0] want_a05, want_zero;
`ifdef HEX_SCAN_DISPLAY_LZB_EN
    want_a05  = {7'h7F, 7'h7F, 7'h7F, 7'h08, 7'h40, 7'h12};
    want_zero = {{5{7'h7F}}, 7'h40};
`else
    want_a05  = {7'h40, 7'h40, 7'h40, 7'h08, 7'h40, 7'h12};
    want_zero = {6{7'h40}};
`endif
    Blink_mask = '0; Value = 24'h000A05; Load = 1'b1;
    tick();
    Load = 1'b0;
    drain("lzb_a05");
    total_cnt++;
    if (HEX !== want_a05) $display("FAIL lzb_a05: got %h want %h", HEX, want_a05); else pass_cnt++;
    Value = 24'h000000; Load = 1'b1;
    tick();
    Load = 1'b0;
    drain("lzb_zero");
    total_cnt++;
    if (HEX !== want_zero) $display("FAIL lzb_zero: got %h want %h", HEX, want_zero); else pass_cnt++;
  endtask

  task automatic test_one_digit();
    value1 = 4'hC; load1 = 1'b1;
    tick();
    load1 = 1'b0;
    total_cnt++;
    if (busy1 !== 1'b1) $display("FAIL d1_busy_high: got %b want 1", busy1); else pass_cnt++;
    tick();
    total_cnt++;
    if (busy1 !== 1'b0) $display("FAIL d1_busy_low: got %b want 0", busy1); else pass_cnt++;
    total_cnt++;
    if (shown1 !== 4'hC) $display("FAIL d1_shown: got %h want c", shown1); else pass_cnt++;
    total_cnt++;
    if (hex1 !== 7'h46) $display("FAIL d1_hex: got %h want 46", hex1); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_single_load();
    test_back_to_back();
    test_blink();
    test_random();
    test_reset_mid_write();
    test_lzb();
    test_one_digit();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
